// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, register-index width
// and the grouped stall/flush enables driven by the hazard controller.
package pipeline_hazard_controller_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned STATE_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_e;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
  } stall_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } flush_t;

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous active-low clear.
module saturating_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: resolves memory waits,
// MEM-stage redirects and load-use hazards, and keeps performance counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned MAX_WAIT    = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [REG_IDX_W-1:0]   idRs1,
  input  logic [REG_IDX_W-1:0]   idRs2,
  input  logic                   idUsesRs1,
  input  logic                   idUsesRs2,
  input  logic                   exMemoryReadEnable,
  input  logic [REG_IDX_W-1:0]   exRd,
  input  logic                   memPcUpdate,
  input  logic                   memAccess,
  input  logic                   memReady,
  output logic                   pcStall,
  output logic                   ifIdStall,
  output logic                   idExStall,
  output logic                   exMemStall,
  output logic                   ifIdFlush,
  output logic                   idExFlush,
  output logic                   exMemFlush,
  output logic                   memWbFlush,
  output logic [STATE_W-1:0]     state,
  output logic                   memTimeout,
  output logic [COUNT_WIDTH-1:0] stallCount,
  output logic [COUNT_WIDTH-1:0] flushCount
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  logic              memHold;
  logic              loadUse;
  state_e            state_q;
  state_e            state_d;
  logic [WAIT_W-1:0] waitCount_q;
  logic [WAIT_W-1:0] waitCount_d;
  logic              memTimeout_q;
  logic              memTimeout_d;
  stall_t            stall_c;
  flush_t            flush_c;

  assign memHold = memAccess & ~memReady;
  assign loadUse = exMemoryReadEnable & (exRd != '0) &
                   ((idUsesRs1 & (idRs1 == exRd)) | (idUsesRs2 & (idRs2 == exRd)));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority memHold > redirect > load-use; LOAD_STALL detects exactly like RUN.
  always_comb begin
    state_d = ST_RUN;
    if (memHold) begin
      state_d = ST_MEM_WAIT;
    end else if (!memPcUpdate && loadUse) begin
      state_d = ST_LOAD_STALL;
    end
  end

  always_comb begin
    stall_c = '0;
    flush_c = '0;
    if (reset) begin
      if (memHold) begin
        stall_c        = '1;
        flush_c.mem_wb = 1'b1;
      end else if (memPcUpdate) begin
        flush_c.if_id  = 1'b1;
        flush_c.id_ex  = 1'b1;
        flush_c.ex_mem = 1'b1;
      end else if (loadUse) begin
        stall_c.pc     = 1'b1;
        stall_c.if_id  = 1'b1;
        flush_c.id_ex  = 1'b1;
      end
    end
  end

  // Wait counter saturates at MAX_WAIT; a further hold cycle arms the sticky timeout.
  always_comb begin
    waitCount_d  = '0;
    memTimeout_d = memTimeout_q;
    if (memHold) begin
      if (waitCount_q == WAIT_W'(MAX_WAIT)) begin
        waitCount_d  = waitCount_q;
        memTimeout_d = 1'b1;
      end else begin
        waitCount_d  = waitCount_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      waitCount_q  <= '0;
      memTimeout_q <= 1'b0;
    end else begin
      waitCount_q  <= waitCount_d;
      memTimeout_q <= memTimeout_d;
    end
  end

  saturating_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_stall_count (
    .clk_i   (clock),
    .clr_ni  (reset),
    .inc_i   (stall_c.pc),
    .count_o (stallCount)
  );

  saturating_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_flush_count (
    .clk_i   (clock),
    .clr_ni  (reset),
    .inc_i   (|flush_c),
    .count_o (flushCount)
  );

  assign pcStall    = stall_c.pc;
  assign ifIdStall  = stall_c.if_id;
  assign idExStall  = stall_c.id_ex;
  assign exMemStall = stall_c.ex_mem;
  assign ifIdFlush  = flush_c.if_id;
  assign idExFlush  = flush_c.id_ex;
  assign exMemFlush = flush_c.ex_mem;
  assign memWbFlush = flush_c.mem_wb;
  assign state      = state_q;
  assign memTimeout = memTimeout_q;

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the five-stage pipeline. It watches the ID, EX and MEM stages and drives per-register stall and flush enables for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazard types: load-use bubbles, branch/jump redirects from MEM, and multi-cycle data-memory waits. Sits beside the datapath; every pipeline register's enable/clear is sourced here.

## Interface
- MAX_WAIT, 16, data-memory wait cycles before `memTimeout` is raised (≥1)
- COUNT_WIDTH, 16, width of the saturating stall/flush performance counters
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; 0 at a rising edge resets all state
- idRs1, idRs2  in  5 each  source registers of the instruction in ID
- idUsesRs1, idUsesRs2  in  1 each  ID instruction actually reads rs1/rs2
- exMemoryReadEnable  in  1  instruction in EX is a load
- exRd  in  5  destination of the instruction in EX
- memPcUpdate  in  1  MEM-stage redirect (taken branch or jump)
- memAccess  in  1  MEM stage has a load or store in flight
- memReady  in  1  data memory completes the MEM access this cycle
- pcStall, ifIdStall, idExStall, exMemStall  out  1 each  hold register contents
- ifIdFlush, idExFlush, exMemFlush, memWbFlush  out  1 each  load bubble (all-zero control)
- state  out  2  RUN=0, LOAD_STALL=1, MEM_WAIT=2
- memTimeout  out  1  sticky: a memory wait exceeded MAX_WAIT
- stallCount, flushCount  out  COUNT_WIDTH each  saturating event counters

## Operation
- memHold = memAccess & ~memReady
- loadUse = exMemoryReadEnable & exRd≠0 & ((idUsesRs1 & idRs1==exRd) | (idUsesRs2 & idRs2==exRd))
- Priority: memHold > memPcUpdate > loadUse. A lower-priority event is ignored in any cycle where a higher one is active. It is re-evaluated in the following cycle from the live inputs.
- memHold:
  - Assert pcStall, ifIdStall, idExStall, exMemStall and memWbFlush. No other flush is asserted.
  - Next state is MEM_WAIT.
- Redirect (memPcUpdate and no memHold):
  - Assert ifIdFlush, idExFlush, exMemFlush. No stall is asserted, so the PC loads the target.
  - Next state is RUN.
- Load-use (no higher event):
  - Assert pcStall, ifIdStall, idExFlush.
  - Next state is LOAD_STALL.
- No event: all outputs 0; next state RUN.
- LOAD_STALL is informational only. Detection in that state is identical to RUN. Because EX now holds a bubble, a second consecutive load-use stall from the same load cannot occur.
- MEM_WAIT:
  - waitCount increments on every memHold cycle and saturates at MAX_WAIT.
  - When memHold is still true with waitCount==MAX_WAIT, memTimeout is set at the next edge. It stays set until reset; stalling continues regardless.
  - The first cycle with memReady=1 drops all stalls combinationally, returns to RUN, and clears waitCount.
- stallCount increments on every cycle with pcStall=1. flushCount increments on every cycle with any flush=1. Both saturate at all-ones and never wrap.

## Timing
- Stall/flush outputs are combinational from current inputs; zero-cycle response. state, waitCount, memTimeout and the counters are registered.
- Load-use costs exactly 1 bubble. A redirect costs 3 squashed slots in a single cycle. A memory wait costs N stall cycles for N cycles of memReady=0.
- Reset (reset=0 at an edge):
  - state=RUN; waitCount, memTimeout, stallCount, flushCount all 0.
  - While reset=0, all stall/flush outputs are forced to 0.
  - Reset mid-MEM_WAIT abandons the wait with no timeout.
- memPcUpdate arriving during MEM_WAIT is held off until memReady. Upstream flushes are issued in the memReady cycle, since the redirecting instruction is then leaving MEM.

## Structure
- Shared pipeline package: state encoding constants (RUN, LOAD_STALL, MEM_WAIT) and the register-index width (5).
- One sub-module, `saturating_counter` (parameterised width, increment enable, synchronous active-low clear), instantiated twice.
- The hazard compare and FSM stay in this module.

## Test plan
- exMemoryReadEnable=1, exRd=5, idRs1=5, idUsesRs1=1 → one cycle of pcStall=ifIdStall=idExFlush=1, state=LOAD_STALL next, stallCount=1. Repeat with exRd=0 → no stall.
- memPcUpdate=1 for one cycle → ifIdFlush=idExFlush=exMemFlush=1, pcStall=0, flushCount=1, state stays RUN.
- memAccess=1, memReady=0 for 3 cycles, then 1 → 3 cycles of all four stalls plus memWbFlush; state=MEM_WAIT; stalls drop in the memReady cycle; state RUN after it; stallCount=3.
- MAX_WAIT=4, memReady held 0 for 6 cycles → memTimeout rises after the 5th hold cycle, stays 1 after memReady, and clears only on reset=0.
- memHold, memPcUpdate and loadUse all true together → only the memHold pattern is driven. After memReady, the redirect flush is issued and the load-use stall is suppressed in that cycle.
- reset=0 asserted during MEM_WAIT with counters nonzero → next cycle state=RUN, counters=0, memTimeout=0, all stall/flush outputs 0 while reset=0.
